// File: rtl/ccm_ctr_stream.sv
// CCM counter-mode streaming datapath: buffers WIDTH-bit beats into a key-wide block,
// XORs it with AES keystream for {flag, nonce, counter}, streams the result back out.
// Build option: CCM_CTR_KS_PLACEHOLDER_EN replaces the AES handshake with ks_ctr_block ^ key_aes.
module ccm_ctr_stream #(
   parameter int WIDTH       = 8,
   parameter int WIDTH_NONCE = 100,
   parameter int WIDTH_FLAG  = 8,
   parameter int WIDTH_COUNT = 20,
   localparam int WIDTH_KEY  = WIDTH_FLAG + WIDTH_NONCE + WIDTH_COUNT
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [WIDTH_NONCE-1:0] ccm_ctr_nonce,
   input  logic [WIDTH_FLAG-1:0]  ccm_ctr_flag,
   input  logic [WIDTH_COUNT-1:0] ctr_init,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_valid,
   input  logic                   in_last,
   output logic                   in_ready,
   output logic                   ks_req,
   output logic [WIDTH_KEY-1:0]   ks_ctr_block,
   input  logic                   ks_valid,
   input  logic [WIDTH_KEY-1:0]   ks_data,
   input  logic [WIDTH_KEY-1:0]   key_aes,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_valid,
   output logic                   out_last,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   ctr_wrap_err
);

   localparam int BEATS = WIDTH_KEY / WIDTH;
   localparam int CW    = $clog2(BEATS + 1);

   typedef enum logic [1:0] {IDLE, FILL, KS, DRAIN} state_t;

   state_t                 state, state_nxt;
   logic [WIDTH_NONCE-1:0] nonce_q;
   logic [WIDTH_FLAG-1:0]  flag_q;
   logic [WIDTH_COUNT-1:0] counter_q;
   logic [WIDTH_KEY-1:0]   in_buf, out_buf;
   logic [CW-1:0]          fill_cnt, blk_cnt, out_cnt;
   logic                   last_q, wrap_q;

   logic                   fill_done, drain_done, ks_fire;
   logic [CW-1:0]          pad_beats;
   logic [WIDTH_KEY-1:0]   in_shift, ctr_block, keystream;

   assign ctr_block  = {flag_q, nonce_q, counter_q};
   assign fill_done  = in_valid && ((fill_cnt == CW'(BEATS - 1)) || in_last);
   assign drain_done = out_ready && (out_cnt == blk_cnt - 1'b1);
   assign in_shift   = {in_buf[WIDTH_KEY-WIDTH-1:0], in_data};
   assign pad_beats  = CW'(BEATS - 1) - fill_cnt;

`ifdef CCM_CTR_KS_PLACEHOLDER_EN
   logic unused_ks;
   assign unused_ks = ks_valid ^ (^ks_data);
   assign ks_fire   = (state == KS);
   assign keystream = ctr_block ^ key_aes;
`else
   logic unused_key;
   assign unused_key = ^key_aes;
   assign ks_fire    = (state == KS) && ks_valid;
   assign keystream  = ks_data;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      ks_req    = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = FILL;
         FILL: begin
            in_ready = 1'b1;
            if (fill_done) state_nxt = KS;
         end
         KS: begin
`ifndef CCM_CTR_KS_PLACEHOLDER_EN
            ks_req = 1'b1;
`endif
            if (ks_fire) state_nxt = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (drain_done) state_nxt = last_q ? IDLE : FILL;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         nonce_q   <= '0;
         flag_q    <= '0;
         counter_q <= '0;
         in_buf    <= '0;
         out_buf   <= '0;
         fill_cnt  <= '0;
         blk_cnt   <= '0;
         out_cnt   <= '0;
         last_q    <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  nonce_q   <= ccm_ctr_nonce;
                  flag_q    <= ccm_ctr_flag;
                  counter_q <= ctr_init;
                  wrap_q    <= 1'b0;
                  in_buf    <= '0;
                  fill_cnt  <= '0;
                  last_q    <= 1'b0;
               end
            end
            FILL: begin
               if (fill_done) begin
                  // left-align a short block; stale high bits fall off the top
                  in_buf   <= in_shift << (pad_beats * WIDTH);
                  blk_cnt  <= fill_cnt + 1'b1;
                  last_q   <= in_last;
                  fill_cnt <= '0;
               end else if (in_valid) begin
                  in_buf   <= in_shift;
                  fill_cnt <= fill_cnt + 1'b1;
               end
            end
            KS: begin
               if (ks_fire) begin
                  out_buf   <= in_buf ^ keystream;
                  counter_q <= counter_q + 1'b1;
                  if (&counter_q) wrap_q <= 1'b1;
                  out_cnt   <= '0;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  out_buf <= out_buf << WIDTH;
                  out_cnt <= out_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign ks_ctr_block = (state == KS) ? ctr_block : '0;
   assign out_data     = out_valid ? out_buf[WIDTH_KEY-1 -: WIDTH] : '0;
   assign out_last     = out_valid && last_q && (out_cnt == blk_cnt - 1'b1);
   assign busy         = (state != IDLE);
   assign ctr_wrap_err = wrap_q;

endmodule

// File: tb/tb_ccm_ctr_stream.sv
// Scoreboard bench for ccm_ctr_stream (default build): random AES latency, random
// valid/ready, expected beats queued at input acceptance and checked by an output monitor.
`timescale 1ns/1ps
module tb_ccm_ctr_stream;
   localparam int BEATS = 16;

   logic         clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [99:0]  ccm_ctr_nonce = '0;
   logic [7:0]   ccm_ctr_flag = '0;
   logic [19:0]  ctr_init = '0;
   logic [7:0]   in_data = '0;
   logic         in_valid = 1'b0, in_last = 1'b0, in_ready;
   logic         ks_req;
   logic [127:0] ks_ctr_block;
   logic         ks_valid = 1'b0;
   logic [127:0] ks_data = '0, key_aes = '0;
   logic [7:0]   out_data;
   logic         out_valid, out_last, out_ready = 1'b0;
   logic         busy, ctr_wrap_err;

   int n_checks = 0, n_fail = 0;
   bit aes_hold = 1'b0;

   typedef struct {logic [7:0] d; int pos; bit last;} beat_t;
   beat_t        exp_q[$];
   logic [127:0] ctr_q[$];
   logic [127:0] ks_q[$];

   ccm_ctr_stream dut (
      .clk(clk), .reset(reset), .start(start),
      .ccm_ctr_nonce(ccm_ctr_nonce), .ccm_ctr_flag(ccm_ctr_flag), .ctr_init(ctr_init),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .ks_req(ks_req), .ks_ctr_block(ks_ctr_block), .ks_valid(ks_valid), .ks_data(ks_data),
      .key_aes(key_aes),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
      .busy(busy), .ctr_wrap_err(ctr_wrap_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event missing or unexpected", name);
   endtask

   // AES stand-in: checks the requested counter block, answers after a random delay
   initial begin
      bit           seen = 1'b0;
      int           dly = 0;
      logic [127:0] k;
      forever begin
         @(negedge clk);
         ks_valid = 1'b0;
         if (reset) seen = 1'b0;
         else if (ks_req && !aes_hold) begin
            if (!seen) begin
               seen = 1'b1;
               dly  = $urandom_range(0, 4);
               if (ctr_q.size() == 0) fail_now("ks_req_unexpected");
               else check("ks_ctr_block", ks_ctr_block, ctr_q.pop_front());
            end else if (dly > 0) dly--;
            if (dly == 0) begin
               k = {$urandom(), $urandom(), $urandom(), $urandom()};
               ks_data  = k;
               ks_valid = 1'b1;
               ks_q.push_back(k);
               seen = 1'b0;
            end
         end
      end
   end

   // output monitor: random back-pressure, stability while stalled, scoreboard compare
   initial begin
      logic [7:0]   prev_d = '0;
      bit           prev_stall = 1'b0;
      beat_t        b;
      logic [127:0] cur_ks = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_stall = 1'b0;
            out_ready  = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_valid", out_valid, 1);
               check("stall_data", out_data, prev_d);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid) check("in_ready_drain", in_ready, 0);
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) fail_now("out_unexpected");
               else begin
                  b = exp_q.pop_front();
                  if (b.pos == 0) begin
                     if (ks_q.size() == 0) fail_now("ks_missing");
                     else cur_ks = ks_q.pop_front();
                  end
                  check("out_data", out_data, b.d ^ cur_ks[127-8*b.pos -: 8]);
                  check("out_last", out_last, b.last);
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
         end
      end
   end

   task automatic send_msg(input int n, input logic [19:0] ci, input bit seq_data,
                           input bit score, input bit inject);
      logic [99:0] nonce;
      logic [7:0]  flag;
      logic [19:0] c;
      int          nblk, i, guard;
      bit          acc, exp_wrap;
      beat_t       b;
      nonce    = 100'({$urandom(), $urandom(), $urandom(), $urandom()});
      flag     = 8'($urandom());
      nblk     = (n + BEATS - 1) / BEATS;
      exp_wrap = 1'b0;
      for (int k = 0; k < nblk; k++) begin
         c = ci + 20'(k);
         if (score) ctr_q.push_back({flag, nonce, c});
         if (c == '1) exp_wrap = 1'b1;
      end
      @(negedge clk);
      start = 1'b1; ccm_ctr_nonce = nonce; ccm_ctr_flag = flag; ctr_init = ci;
      @(negedge clk);
      start = 1'b0;
      i = 0; guard = 0;
      while (i < n && guard < 5000) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = seq_data ? 8'(i) : 8'($urandom());
         in_last  = (i == n - 1);
         start    = inject && (i == 3);
         if (start) begin ccm_ctr_nonce = ~nonce; ctr_init = ~ci; end
         acc = in_valid && in_ready;
         if (acc && score) begin
            b.d = in_data; b.pos = i % BEATS; b.last = (i == n - 1);
            exp_q.push_back(b);
         end
         @(negedge clk);
         if (acc) i++;
         guard++;
      end
      in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
      if (i < n) fail_now("in_timeout");
      guard = 0;
      while (busy && guard < 3000) begin @(negedge clk); guard++; end
      if (busy) fail_now("drain_timeout");
      if (score) begin
         check("exp_q_empty", exp_q.size(), 0);
         check("ctr_q_empty", ctr_q.size(), 0);
         check("wrap_err", ctr_wrap_err, exp_wrap);
      end
   endtask

   initial begin
      int guard;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_ks_req", ks_req, 0);
      check("rst_out_valid", out_valid, 0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_outputs", {ks_ctr_block, out_data, out_last, ctr_wrap_err}, '0);

      send_msg(16, 20'h1, 1, 1, 0);
      send_msg(20, 20'h1, 1, 1, 0);
      send_msg(16, 20'hFFFFF, 0, 1, 0);
      send_msg(5, 20'h10, 0, 1, 0);
      send_msg(12, 20'h7, 0, 1, 1);

      // reset while a keystream request is outstanding
      aes_hold = 1'b1;
      @(negedge clk);
      start = 1'b1; ctr_init = 20'h55;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < BEATS; k++) begin
         in_valid = 1'b1; in_data = 8'($urandom()); in_last = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b0;
      guard = 0;
      while (!ks_req && guard < 50) begin @(negedge clk); guard++; end
      check("ks_req_pending", ks_req, 1);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_outputs",
            {ks_ctr_block, out_data, out_last, out_valid, ks_req, in_ready, busy, ctr_wrap_err}, '0);
      reset = 1'b0;
      #1 ks_valid = 1'b1; ks_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      check("late_ks_ignored", {busy, out_valid, ks_req}, '0);
      aes_hold = 1'b0;

      for (int m = 0; m < 8; m++)
         send_msg($urandom_range(1, 40),
                  ($urandom_range(0, 3) == 0) ? 20'hFFFFE : 20'($urandom()), 0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
